// File: rtl/sched_shared_alu_pkg.sv
// Shared types for the single-ALU scheduled datapath: FSM states, ALU opcodes
// and the length of the operation schedule.
package sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OP1  = 3'd1,
        OP2  = 3'd2,
        OP3  = 3'd3,
        OP4  = 3'd4,
        OP5  = 3'd5,
        DONE = 3'd6
    } sched_state_t;

    typedef enum logic [1:0] {
        ADD   = 2'd0,
        SUB   = 2'd1,
        MUL   = 2'd2,
        CMPGT = 2'd3
    } alu_op_t;

    localparam int NUM_STEPS = 5;

endpackage

// File: rtl/sched_shared_alu_if.sv
// Request/result bundle of sched_shared_alu: start plus operands in,
// busy/done status and the registered results out.
interface sched_shared_alu_if #(
    parameter int DATAWIDTH = 8
) ();

    logic                     start;
    logic [DATAWIDTH-1:0]     a;
    logic [DATAWIDTH-1:0]     b;
    logic [DATAWIDTH-1:0]     c;
    logic                     busy;
    logic                     done;
    logic [DATAWIDTH-1:0]     z;
    logic [2*DATAWIDTH-1:0]   x;

    modport master (
        output start, a, b, c,
        input  busy, done, z, x
    );

    modport slave (
        input  start, a, b, c,
        output busy, done, z, x
    );

endinterface

// File: rtl/sched_shared_alu_alu.sv
// Combinational signed ALU shared by every step of the schedule.
// CMPGT returns the compare result in bit 0 with all upper bits zero.
module shared_alu
    import sched_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        unique case (op)
            ADD:   res = opa + opb;
            SUB:   res = opa - opb;
            // Low WIDTH bits of the product are identical for signed and unsigned
            MUL:   res = opa * opb;
            CMPGT: res = {{(WIDTH-1){1'b0}}, ($signed(opa) > $signed(opb))};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/sched_shared_alu.sv
// Five-step scheduled evaluation of z = max(a+b, a+c) and x = a*c - (a+b)
// on one shared ALU; operands captured on start, done pulses once at the end.
module sched_shared_alu
    import sched_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    sched_shared_alu_if.slave  bus
);

    localparam int W2 = 2 * DATAWIDTH;

    sched_state_t          state_reg, state_next;
    logic [DATAWIDTH-1:0]  ra_reg, rb_reg, rc_reg;
    logic [DATAWIDTH-1:0]  d_reg, e_reg, z_reg;
    logic [W2-1:0]         f_reg, x_reg;
    logic                  g_reg, g_next;

    alu_op_t               alu_op;
    logic [W2-1:0]         alu_opa, alu_opb, alu_res;

    function automatic logic [W2-1:0] sext(input logic [DATAWIDTH-1:0] v);
        return {{DATAWIDTH{v[DATAWIDTH-1]}}, v};
    endfunction

    shared_alu #(
        .WIDTH (W2)
    ) u_alu (
        .opa (alu_opa),
        .opb (alu_opb),
        .op  (alu_op),
        .res (alu_res)
    );

    // Next state plus per-step operand/opcode selection for the shared ALU
    always_comb begin
        state_next = state_reg;
        alu_op     = ADD;
        alu_opa    = '0;
        alu_opb    = '0;
        unique case (state_reg)
            IDLE: if (bus.start) state_next = OP1;
            OP1: begin
                alu_opa    = sext(ra_reg);
                alu_opb    = sext(rb_reg);
                state_next = OP2;
            end
            OP2: begin
                alu_opa    = sext(ra_reg);
                alu_opb    = sext(rc_reg);
                state_next = OP3;
            end
            OP3: begin
                alu_op     = MUL;
                alu_opa    = sext(ra_reg);
                alu_opb    = sext(rc_reg);
                state_next = OP4;
            end
            OP4: begin
                alu_op     = CMPGT;
                alu_opa    = sext(d_reg);
                alu_opb    = sext(e_reg);
                state_next = OP5;
            end
            OP5: begin
                alu_op     = SUB;
                alu_opa    = f_reg;
                alu_opb    = sext(d_reg);
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The compare result is consumed in the same edge that records it
    assign g_next = (state_reg == OP4) ? alu_res[0] : g_reg;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg <= IDLE;
            ra_reg    <= '0;
            rb_reg    <= '0;
            rc_reg    <= '0;
            d_reg     <= '0;
            e_reg     <= '0;
            f_reg     <= '0;
            g_reg     <= 1'b0;
            z_reg     <= '0;
            x_reg     <= '0;
        end else begin
            state_reg <= state_next;
            g_reg     <= g_next;
            unique case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        ra_reg <= bus.a;
                        rb_reg <= bus.b;
                        rc_reg <= bus.c;
                    end
                end
                OP1:     d_reg <= alu_res[DATAWIDTH-1:0];
                OP2:     e_reg <= alu_res[DATAWIDTH-1:0];
                OP3:     f_reg <= alu_res;
                OP4:     z_reg <= g_next ? d_reg : e_reg;
                OP5:     x_reg <= alu_res;
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = (state_reg == DONE);
    assign bus.z    = z_reg;
    assign bus.x    = x_reg;

endmodule

// File: tb/tb_sched_shared_alu.sv
// Randomized self-checking bench for sched_shared_alu against an arithmetic
// reference model; one line per transaction, single summary line at the end.
module tb_sched_shared_alu;
    import sched_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    sched_shared_alu_if #(.DATAWIDTH(8)) bus ();

    sched_shared_alu #(
        .DATAWIDTH (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Plain-integer model: wrap sums to 8 bits, pick the larger, subtract from a*c
    function automatic void ref_calc(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c,
                                     output logic [7:0] z, output logic [15:0] x);
        int sa, sb, sc, d, e;
        sa = $signed(a);
        sb = $signed(b);
        sc = $signed(c);
        d  = sa + sb;
        if (d > 127)  d -= 256;
        if (d < -128) d += 256;
        e  = sa + sc;
        if (e > 127)  e -= 256;
        if (e < -128) e += 256;
        z  = 8'((d > e) ? d : e);
        x  = 16'(sa * sc - d);
    endfunction

    // One start pulse, operands scrambled after capture, 10-cycle observation window
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] ez, input logic [15:0] ex);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        @(negedge CLK);
        bus.a = a; bus.b = b; bus.c = c; bus.start = 1'b1;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.c = 8'($urandom);
        for (int n = 1; n <= 10; n++) begin
            @(negedge CLK);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at = n;
            end
        end
        check("done_latency", done_at, 6);
        check("done_width", done_cnt, 1);
        check("busy_cycles", busy_cnt, NUM_STEPS + 1);
        check("z", bus.z, ez);
        check("x", bus.x, ex);
        $display("op a=%0d b=%0d c=%0d -> z=0x%02h x=0x%04h (want z=0x%02h x=0x%04h)",
                 $signed(a), $signed(b), $signed(c), bus.z, bus.x, ez, ex);
    endtask

    initial begin
        logic [7:0]  ra, rb, rc, mz;
        logic [15:0] mx;
        logic [23:0] exp_q[$];
        logic [23:0] front;
        int          phase;
        int          hold_done, post_busy, post_done;

        RST = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_z", bus.z, 0);
        check("rst_x", bus.x, 0);
        RST = 1'b1;

        // Directed vectors with hand-derived results
        do_op(8'd3,   8'd4,   8'd5,   8'h08, 16'h0008);
        do_op(8'd10,  8'd20,  8'hFB,  8'h1E, 16'hFFB0);
        do_op(8'hFE,  8'hFD,  8'd100, 8'h62, 16'hFF3D);
        do_op(8'd100, 8'd100, 8'd1,   8'h65, 16'h009C);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
            ref_calc(ra, rb, rc, mz, mx);
            do_op(ra, rb, rc, mz, mx);
        end

        // start held high: a new run is accepted only on an edge seen in IDLE,
        // i.e. six busy cycles then one idle cycle per run
        phase = 0;
        hold_done = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge CLK);
            check("hold_busy", bus.busy, (phase != 0) ? 1 : 0);
            check("hold_done", bus.done, (phase == 6) ? 1 : 0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("hold_queue", 0, 1);
                end else begin
                    front = exp_q.pop_front();
                    check("hold_z", bus.z, front[23:16]);
                    check("hold_x", bus.x, front[15:0]);
                    hold_done++;
                    $display("hold run %0d: z=0x%02h x=0x%04h (want z=0x%02h x=0x%04h)",
                             hold_done, bus.z, bus.x, front[23:16], front[15:0]);
                end
            end
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
            bus.a = ra; bus.b = rb; bus.c = rc; bus.start = 1'b1;
            if (phase == 0) begin
                ref_calc(ra, rb, rc, mz, mx);
                exp_q.push_back({mz, mx});
                phase = 1;
            end else if (phase == 6) begin
                phase = 0;
            end else begin
                phase++;
            end
        end
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (10) @(negedge CLK);
        exp_q.delete();

        // Reset asserted while the FSM sits in OP3
        @(negedge CLK);
        bus.a = 8'd7; bus.b = 8'd9; bus.c = 8'hF0; bus.start = 1'b1;
        @(posedge CLK);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_z", bus.z, 0);
        check("midrst_x", bus.x, 0);
        post_busy = 0;
        post_done = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge CLK);
            if (bus.busy) post_busy++;
            if (bus.done) post_done++;
        end
        check("midrst_no_done", post_done, 0);
        check("midrst_idle", post_busy, 0);
        $display("mid-op reset: busy_after=%0d done_after=%0d", post_busy, post_done);

        ref_calc(8'd7, 8'd9, 8'hF0, mz, mx);
        do_op(8'd7, 8'd9, 8'hF0, mz, mx);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
